// File: rtl/l1a_lct_match.sv
// l1a_lct_match: delays LCT pretriggers by a programmable latency, opens a
// programmable match window, and pairs each L1A with at most one LCT.
// A matched L1A pulses L1A_MATCH; an unmatched one pulses L1A_HEAD when enabled.
// A capture FSM tracks the sample window and flags overlapping matches.
// Optional build macro: L1A_MATCH_STATS_EN adds saturating event counters.
module l1a_lct_match #(
   parameter int DLY_DEPTH = 64,
   parameter int WIN_MAX   = 16
) (
   input  logic        CMSCLK,
   input  logic        rst_resync,
   input  logic        LCT,
   input  logic        L1A,
   input  logic [5:0]  LCT_L1A_DLY,
   input  logic [4:0]  WIN_SIZE,
   input  logic [6:0]  CAPT_LEN,
   input  logic        HDR_ONLY_EN,
   output logic        L1A_MATCH,
   output logic        L1A_HEAD,
   output logic        OVLP,
   output logic        CAPT_BUSY
`ifdef L1A_MATCH_STATS_EN
   ,
   output logic [11:0] LCT_CNT,
   output logic [11:0] NOMATCH_CNT,
   output logic [7:0]  OVLP_CNT
`endif
);

   localparam int PW = $clog2(DLY_DEPTH);

   typedef enum logic {IDLE, CAPT} state_t;

   logic [DLY_DEPTH-1:0] hist;
   logic [PW-1:0]        wp;
   logic [PW-1:0]        rd_ptr;
   logic                 dl;
   logic                 dly_zero;

   logic [WIN_MAX-1:0]   win_sr;
   logic [WIN_MAX-1:0]   mask;
   logic [WIN_MAX-1:0]   masked;
   logic [WIN_MAX-1:0]   clr;
   logic [WIN_MAX-1:0]   win_keep;
   logic                 dl_hit;
   logic                 dl_used;
   logic                 hit;
   logic                 match;
   logic                 nomatch;

   state_t               state;
   logic [6:0]           cnt;

   assign dly_zero = (LCT_L1A_DLY == 6'd0);
   assign rd_ptr   = wp - PW'(LCT_L1A_DLY);

   // Delayed LCT; zero delay bypasses the history so the current LCT is seen
   always_comb begin
      dl = hist[rd_ptr];
      if (dly_zero) dl = LCT;
   end

   // LCT history ring: one bit written per cycle, pointer wraps naturally
   always_ff @(posedge CMSCLK or posedge rst_resync) begin
      if (rst_resync) begin
         hist <= '0;
         wp   <= '0;
      end else begin
         hist[wp] <= LCT;
         wp       <= wp + 1'b1;
      end
   end

   // Window mask: low WIN_SIZE bits, WIN_SIZE clipped to the register width
   always_comb begin
      int win_len;
      win_len = (int'(WIN_SIZE) > WIN_MAX) ? WIN_MAX : int'(WIN_SIZE);
      mask = '0;
      for (int i = 0; i < WIN_MAX; i++) mask[i] = (i < win_len);
   end

   assign masked  = win_sr & mask;
   // With zero delay the same-cycle LCT is eligible as the youngest candidate
   assign dl_hit  = dly_zero && (WIN_SIZE != 5'd0) && dl;
   assign hit     = (|masked) || dl_hit;
   assign match   = L1A && hit;
   assign nomatch = L1A && !hit;

   // Oldest in-window LCT (highest index) is the one an L1A consumes
   always_comb begin
      clr = '0;
      for (int i = 0; i < WIN_MAX; i++) begin
         if (masked[i]) begin
            clr    = '0;
            clr[i] = 1'b1;
         end
      end
   end

   // The bypassed LCT is consumed only when nothing older was in the window
   assign dl_used  = match && (masked == '0);
   assign win_keep = match ? (win_sr & ~clr) : win_sr;

   // Window shift register with consumption applied before the shift
   always_ff @(posedge CMSCLK or posedge rst_resync) begin
      if (rst_resync) win_sr <= '0;
      else            win_sr <= {win_keep[WIN_MAX-2:0], dl & ~dl_used};
   end

   // Registered 1-cycle match / header pulses, mutually exclusive by construction
   always_ff @(posedge CMSCLK or posedge rst_resync) begin
      if (rst_resync) begin
         L1A_MATCH <= 1'b0;
         L1A_HEAD  <= 1'b0;
      end else begin
         L1A_MATCH <= match;
         L1A_HEAD  <= nomatch && HDR_ONLY_EN;
      end
   end

   // Capture FSM: busy for CAPT_LEN cycles after a match, restarted on overlap
   always_ff @(posedge CMSCLK or posedge rst_resync) begin
      if (rst_resync) begin
         state     <= IDLE;
         cnt       <= '0;
         OVLP      <= 1'b0;
         CAPT_BUSY <= 1'b0;
      end else begin
         OVLP <= 1'b0;
         case (state)
            IDLE: begin
               if (match && (CAPT_LEN != 7'd0)) begin
                  state     <= CAPT;
                  cnt       <= CAPT_LEN - 7'd1;
                  CAPT_BUSY <= 1'b1;
               end
            end
            CAPT: begin
               if (match) begin
                  OVLP <= 1'b1;
                  if (CAPT_LEN != 7'd0) begin
                     cnt <= CAPT_LEN - 7'd1;
                  end else begin
                     state     <= IDLE;
                     cnt       <= '0;
                     CAPT_BUSY <= 1'b0;
                  end
               end else if (cnt == 7'd0) begin
                  state     <= IDLE;
                  CAPT_BUSY <= 1'b0;
               end else begin
                  cnt <= cnt - 7'd1;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               CAPT_BUSY <= 1'b0;
            end
         endcase
      end
   end

`ifdef L1A_MATCH_STATS_EN
   logic ovlp_evt;
   assign ovlp_evt = match && (state == CAPT);

   // Saturating event counters
   always_ff @(posedge CMSCLK or posedge rst_resync) begin
      if (rst_resync) begin
         LCT_CNT     <= '0;
         NOMATCH_CNT <= '0;
         OVLP_CNT    <= '0;
      end else begin
         if (LCT && (LCT_CNT != '1))         LCT_CNT     <= LCT_CNT + 12'd1;
         if (nomatch && (NOMATCH_CNT != '1)) NOMATCH_CNT <= NOMATCH_CNT + 12'd1;
         if (ovlp_evt && (OVLP_CNT != '1))   OVLP_CNT    <= OVLP_CNT + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l1a_lct_match.sv
// Testbench for l1a_lct_match: scenario tasks push expected output pulses to a
// scoreboard queue; a negedge monitor pops and compares them, and flags any
// pulse nobody expected.
module tb_l1a_lct_match;

   logic        CMSCLK = 1'b0;
   logic        rst_resync = 1'b0;
   logic        LCT = 1'b0;
   logic        L1A = 1'b0;
   logic [5:0]  LCT_L1A_DLY = 6'd10;
   logic [4:0]  WIN_SIZE = 5'd3;
   logic [6:0]  CAPT_LEN = 7'd0;
   logic        HDR_ONLY_EN = 1'b1;
   logic        L1A_MATCH;
   logic        L1A_HEAD;
   logic        OVLP;
   logic        CAPT_BUSY;
`ifdef L1A_MATCH_STATS_EN
   logic [11:0] LCT_CNT;
   logic [11:0] NOMATCH_CNT;
   logic [7:0]  OVLP_CNT;
`endif

   typedef struct {
      int   cyc;
      logic m;
      logic h;
      logic o;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   l1a_lct_match dut (
      .CMSCLK      (CMSCLK),
      .rst_resync  (rst_resync),
      .LCT         (LCT),
      .L1A         (L1A),
      .LCT_L1A_DLY (LCT_L1A_DLY),
      .WIN_SIZE    (WIN_SIZE),
      .CAPT_LEN    (CAPT_LEN),
      .HDR_ONLY_EN (HDR_ONLY_EN),
      .L1A_MATCH   (L1A_MATCH),
      .L1A_HEAD    (L1A_HEAD),
      .OVLP        (OVLP),
      .CAPT_BUSY   (CAPT_BUSY)
`ifdef L1A_MATCH_STATS_EN
      ,
      .LCT_CNT     (LCT_CNT),
      .NOMATCH_CNT (NOMATCH_CNT),
      .OVLP_CNT    (OVLP_CNT)
`endif
   );

   always #5 CMSCLK = ~CMSCLK;

   always @(posedge CMSCLK) cyc <= cyc + 1;

   // Scoreboard monitor: outputs registered at edge N are checked at the negedge after it
   always @(negedge CMSCLK) begin
      exp_t e;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         tests++;
         if ({L1A_MATCH, L1A_HEAD, OVLP} !== {e.m, e.h, e.o}) begin
            fails++;
            $display("FAIL pulse@%0d match/head/ovlp got %b%b%b required %b%b%b",
                     cyc, L1A_MATCH, L1A_HEAD, OVLP, e.m, e.h, e.o);
         end
      end else if ({L1A_MATCH, L1A_HEAD, OVLP} !== 3'b000) begin
         tests++;
         fails++;
         $display("FAIL unexpected_pulse@%0d match/head/ovlp got %b%b%b required 000",
                  cyc, L1A_MATCH, L1A_HEAD, OVLP);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Drive one cycle of stimulus; it is sampled by edge cyc+1
   task automatic step(input logic lct, input logic l1a);
      LCT = lct;
      L1A = l1a;
      @(posedge CMSCLK);
      #1;
      LCT = 1'b0;
      L1A = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic expect_at(input int c, input logic m, input logic h, input logic o);
      exp_t e;
      e.cyc = c; e.m = m; e.h = h; e.o = o;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_resync = 1'b1;
      @(posedge CMSCLK);
      #1;
      rst_resync = 1'b0;
   endtask

   task automatic drain(input string name);
      idle(25);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s pending_expectations got %0d required 0 (next cyc %0d)",
                  name, exp_q.size(), exp_q[0].cyc);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      #1 rst_resync = 1'b1;
      #2;
      tests++;
      if ({L1A_MATCH, L1A_HEAD, OVLP, CAPT_BUSY} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_outputs got %b required 0000",
                  {L1A_MATCH, L1A_HEAD, OVLP, CAPT_BUSY});
      end
      @(posedge CMSCLK);
      #1;
      rst_resync = 1'b0;
      idle(3);
   endtask

   task automatic test_match();
      LCT_L1A_DLY = 6'd10; WIN_SIZE = 5'd3; CAPT_LEN = 7'd0; HDR_ONLY_EN = 1'b1;
      // LCT at p, L1A at p+11 -> match
      step(1'b1, 1'b0);
      idle(10);
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain("match");
      // Window boundaries: p+10 too early (header), p+13 last slot (match)
      step(1'b1, 1'b0);
      idle(9);
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1);
      idle(2);
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain("window_edges");
      // p+14 is one past the window
      step(1'b1, 1'b0);
      idle(13);
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1);
      drain("window_late");
   endtask

   task automatic test_header();
      LCT_L1A_DLY = 6'd10; WIN_SIZE = 5'd3; HDR_ONLY_EN = 1'b1;
      step(1'b1, 1'b0);
      idle(19);
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1);
      drain("header_en");
      HDR_ONLY_EN = 1'b0;
      step(1'b1, 1'b0);
      idle(19);
      expect_at(cyc + 1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain("header_dis");
      HDR_ONLY_EN = 1'b1;
   endtask

   task automatic test_back_to_back();
      LCT_L1A_DLY = 6'd10; WIN_SIZE = 5'd3; HDR_ONLY_EN = 1'b1;
      // One LCT, two L1As in window: second finds it consumed
      step(1'b1, 1'b0);
      idle(10);
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1);
      drain("consume");
      // Two LCTs, two back-to-back L1As: both match
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      idle(10);
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain("two_lcts");
   endtask

   task automatic test_boundaries();
      // Zero delay: same-cycle LCT matches, and is consumed
      LCT_L1A_DLY = 6'd0; WIN_SIZE = 5'd1;
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1);
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1);
      drain("dly0_same_cycle");
      // Nonzero delay: same-cycle LCT cannot match
      LCT_L1A_DLY = 6'd10; WIN_SIZE = 5'd3;
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1);
      drain("dly10_same_cycle");
      // WIN_SIZE = 0 disables matching
      WIN_SIZE = 5'd0;
      step(1'b1, 1'b0);
      idle(10);
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1);
      drain("win0");
      // WIN_SIZE clipped to 16: p+26 matches, p+27 does not
      WIN_SIZE = 5'd31;
      step(1'b1, 1'b0);
      idle(25);
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain("clip_in");
      step(1'b1, 1'b0);
      idle(26);
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1);
      drain("clip_out");
      WIN_SIZE = 5'd3;
   endtask

   task automatic test_capture();
      LCT_L1A_DLY = 6'd10; WIN_SIZE = 5'd3; CAPT_LEN = 7'd8;
      step(1'b1, 1'b0);
      idle(4);
      step(1'b1, 1'b0);
      idle(5);
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (CAPT_BUSY !== 1'b1) begin
            fails++;
            $display("FAIL capt_busy_first+%0d got %b required 1", i, CAPT_BUSY);
         end
         if (i < 4) idle(1);
      end
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         tests++;
         if (CAPT_BUSY !== (i < 8)) begin
            fails++;
            $display("FAIL capt_busy_second+%0d got %b required %b", i, CAPT_BUSY, (i < 8));
         end
         idle(1);
      end
      drain("capture");
      CAPT_LEN = 7'd0;
   endtask

   task automatic test_reset_mid();
      LCT_L1A_DLY = 6'd10; WIN_SIZE = 5'd3; CAPT_LEN = 7'd20; HDR_ONLY_EN = 1'b1;
      step(1'b1, 1'b0);
      idle(10);
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1);
      tests++;
      if (CAPT_BUSY !== 1'b1) begin
         fails++;
         $display("FAIL busy_before_reset got %b required 1", CAPT_BUSY);
      end
      @(negedge CMSCLK);
      #1 rst_resync = 1'b1;
      #1;
      tests++;
      if ({L1A_MATCH, L1A_HEAD, OVLP, CAPT_BUSY} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_mid_outputs got %b required 0000",
                  {L1A_MATCH, L1A_HEAD, OVLP, CAPT_BUSY});
      end
      @(posedge CMSCLK);
      #1 rst_resync = 1'b0;
      // The pending LCT would have matched here had it survived reset
      idle(9);
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1);
      tests++;
      if (CAPT_BUSY !== 1'b0) begin
         fails++;
         $display("FAIL busy_after_reset got %b required 0", CAPT_BUSY);
      end
      drain("reset_mid");
      CAPT_LEN = 7'd0;
   endtask

   task automatic test_wrap();
      LCT_L1A_DLY = 6'd63; WIN_SIZE = 5'd3; CAPT_LEN = 7'd0; HDR_ONLY_EN = 1'b1;
      do_reset();
      idle(62);
      step(1'b1, 1'b0);
      idle(62);
      expect_at(cyc + 1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1);
      expect_at(cyc + 1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      drain("wrap");
      LCT_L1A_DLY = 6'd10;
   endtask

`ifdef L1A_MATCH_STATS_EN
   task automatic test_stats();
      do_reset();
      tests++;
      if ({LCT_CNT, NOMATCH_CNT, OVLP_CNT} !== 32'd0) begin
         fails++;
         $display("FAIL stats_reset got %h/%h/%h required 0/0/0", LCT_CNT, NOMATCH_CNT, OVLP_CNT);
      end
      HDR_ONLY_EN = 1'b0;
      expect_at(cyc + 1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      expect_at(cyc + 1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1);
      tests++;
      if (NOMATCH_CNT !== 12'd2) begin
         fails++;
         $display("FAIL nomatch_cnt got %0d required 2", NOMATCH_CNT);
      end
      HDR_ONLY_EN = 1'b1;
      for (int i = 0; i < 4100; i++) step(1'b1, 1'b0);
      tests++;
      if (LCT_CNT !== 12'hFFF) begin
         fails++;
         $display("FAIL lct_cnt_sat got %h required fff", LCT_CNT);
      end
      tests++;
      if (OVLP_CNT !== 8'd0) begin
         fails++;
         $display("FAIL ovlp_cnt got %0d required 0", OVLP_CNT);
      end
      do_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_match();
      test_header();
      test_back_to_back();
      test_boundaries();
      test_capture();
      test_reset_mid();
      test_wrap();
`ifdef L1A_MATCH_STATS_EN
      test_stats();
`endif
      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
